// File: rtl/audio_pkg.sv
// Shared audio datapath types and constants for the VCA / PDM output path.
package audio_pkg;

    localparam int W_SAMPLE = 16;
    localparam int W_ENV    = 16;

    typedef logic signed [W_SAMPLE-1:0] sample_t;
    typedef logic        [W_ENV-1:0]    env_t;

    // Flipping the MSB maps two's complement onto offset binary for the DAC.
    localparam logic [W_SAMPLE-1:0] PDM_OFFSET = 16'h8000;

    // Stage-1 payload: sample and its (possibly muted) gain.
    typedef struct packed {
        sample_t sample;
        env_t    env;
    } vca_req_t;

endpackage

// File: rtl/pdm_dac.sv
// First-order delta-sigma modulator: carry out of a 16-bit phase accumulator
// driven by the offset-binary level gives a 1-bit stream with duty u/65536.
import audio_pkg::*;

module pdm_dac (
    input  logic    i_clk,
    input  logic    i_reset_n,
    input  sample_t i_level,
    output logic    o_pdm
);

    logic [15:0] u;
    logic [16:0] sum;
    logic [15:0] acc_d, acc_q;
    logic        pdm_d, pdm_q;

    // Offset conversion and accumulate; the carry is the next PDM bit.
    always_comb begin
        u     = 16'(i_level) ^ PDM_OFFSET;
        sum   = {1'b0, acc_q} + {1'b0, u};
        acc_d = sum[15:0];
        pdm_d = sum[16];
    end

    // Accumulator and output bit update every cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end

    assign o_pdm = pdm_q;

endmodule

// File: rtl/env_vca.sv
// Envelope VCA: 3-stage sample x envelope pipeline (capture, multiply,
// floor-shift by W_ENV) feeding a PDM DAC from the held output sample.
import audio_pkg::*;

module env_vca #(
    parameter int W_SAMPLE = audio_pkg::W_SAMPLE,
    parameter int W_ENV    = audio_pkg::W_ENV
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_sample_valid,
    input  logic signed [W_SAMPLE-1:0] i_sample,
    input  logic        [W_ENV-1:0]    i_env,
    input  logic                       i_mute,
    output logic                       o_sample_valid,
    output logic signed [W_SAMPLE-1:0] o_sample,
    output logic                       o_pdm
);

    localparam int STAGES = 3;
    localparam int W_PROD = W_SAMPLE + W_ENV + 1;

    logic [STAGES-1:0]                vld_pipe_d, vld_pipe_q;
    vca_req_t                         s1_d, s1_q;
    logic signed [W_PROD-1:0]         mul_a, mul_b;
    logic signed [W_PROD-1:0]         prod_d, prod_q;
    logic signed [W_SAMPLE-1:0]       o_sample_d, o_sample_q;
    logic                             unused_prod_bits;

    // Valid shift register: gaps and ordering pass through unchanged.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-2:0], i_sample_valid};
    end

    // Stage 1: capture sample and gain only on valid; mute zeroes the gain.
    always_comb begin
        s1_d = s1_q;
        if (i_sample_valid) begin
            s1_d.sample = i_sample;
            s1_d.env    = i_mute ? '0 : i_env;
        end
    end

    // Stage 2: signed sample times zero-extended envelope, full width so the
    // extreme products cannot wrap.
    always_comb begin
        mul_a  = W_PROD'(s1_q.sample);
        mul_b  = W_PROD'({1'b0, s1_q.env});
        prod_d = prod_q;
        if (vld_pipe_q[0])
            prod_d = mul_a * mul_b;
    end

    // Stage 3: arithmetic shift by W_ENV (floor); range already fits W_SAMPLE.
    always_comb begin
        o_sample_d = o_sample_q;
        if (vld_pipe_q[1])
            o_sample_d = prod_q[W_SAMPLE+W_ENV-1:W_ENV];
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            prod_q     <= '0;
            o_sample_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            prod_q     <= prod_d;
            o_sample_q <= o_sample_d;
        end
    end

    // Sign bit and fractional bits are dropped by the shift.
    assign unused_prod_bits = ^{prod_q[W_PROD-1], prod_q[W_ENV-1:0]};

    assign o_sample_valid = vld_pipe_q[STAGES-1];
    assign o_sample       = o_sample_q;

    pdm_dac u_pdm_dac (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_level   (o_sample_q),
        .o_pdm     (o_pdm)
    );

endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca: reset, scaling, mute, streaming, PDM duty,
// reset in flight. Expected values are hand-computed.
module tb_env_vca;

    logic               i_clk = 1'b0;
    logic               i_reset_n = 1'b0;
    logic               i_sample_valid = 1'b0;
    logic signed [15:0] i_sample = '0;
    logic        [15:0] i_env = '0;
    logic               i_mute = 1'b0;
    logic               o_sample_valid;
    logic signed [15:0] o_sample;
    logic               o_pdm;

    int total = 0;
    int bad   = 0;

    env_vca dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_env          (i_env),
        .i_mute         (i_mute),
        .o_sample_valid (o_sample_valid),
        .o_sample       (o_sample),
        .o_pdm          (o_pdm)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One sample driven right after edge k; strobe must appear at edge k+3 only.
    task automatic scale_vec(input string tag, input int s, input int e, input logic m, input int exp);
        i_sample_valid = 1'b1;
        i_sample       = 16'(s);
        i_env          = 16'(e);
        i_mute         = m;
        tick();
        i_sample_valid = 1'b0;
        i_mute         = 1'b0;
        i_sample       = 16'h5a5a;
        i_env          = 16'h1234;
        tick();
        chk({tag, "_early"}, int'(o_sample_valid), 0);
        tick();
        chk({tag, "_vld"}, int'(o_sample_valid), 1);
        chk({tag, "_val"}, int'(o_sample), exp);
        tick();
        chk({tag, "_1cyc"}, int'(o_sample_valid), 0);
        chk({tag, "_hold"}, int'(o_sample), exp);
    endtask

    int          vin  [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
    int          sin  [8] = '{100, -200, 3000, -4001, 5, 0, 0, 7777};
    int          ein  [8] = '{'hFFFF, 'hFFFF, 'h8000, 'h8000, 'h4000, 0, 0, 'hFFFF};
    int          xout [8] = '{99, -200, 1500, -2001, 1, 1, 1, 7776};

    initial begin
        int ones;
        int strobes;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            i_sample_valid = 1'b1;
            i_sample       = 16'($urandom_range(65535));
            i_env          = 16'($urandom_range(65535));
            i_mute         = 1'($urandom_range(1));
        end
        chk("rst_vld", int'(o_sample_valid), 0);
        chk("rst_smp", int'(o_sample), 0);
        chk("rst_pdm", int'(o_pdm), 0);
        i_sample_valid = 1'b0;
        i_mute         = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rst_pdm_seq%0d", i), int'(o_pdm), i % 2);
            chk($sformatf("rst_idle_vld%0d", i), int'(o_sample_valid), 0);
        end

        // Scaling vectors.
        scale_vec("sc_16384", 16384, 'hFFFF, 1'b0, 16383);
        scale_vec("sc_32767", 32767, 'h8000, 1'b0, 16383);
        scale_vec("sc_neg_fs", -32768, 'hFFFF, 1'b0, -32768);
        scale_vec("sc_neg1", -1, 'h0001, 1'b0, -1);
        scale_vec("sc_pos_fs", 32767, 'hFFFF, 1'b0, 32766);

        // Mute only affects its own sample.
        scale_vec("mute_on", 1000, 'hFFFF, 1'b1, 0);
        scale_vec("mute_off", 1000, 'hFFFF, 1'b0, 999);

        // Envelope change without valid must not touch the held output.
        i_env = 16'h0000;
        tick();
        tick();
        tick();
        tick();
        chk("env_noval", int'(o_sample), 999);

        // PDM duty at o_sample = 16384: u = 49152, exactly 3 ones per 4 cycles.
        scale_vec("duty_lvl", 16385, 'hFFFF, 1'b0, 16384);
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(o_pdm);
        end
        chk("pdm_duty", ones, 3072);

        // Streaming: 5 back-to-back, 2-cycle gap, 1 more.
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                i_sample_valid = vin[c][0];
                i_sample       = 16'(sin[c]);
                i_env          = 16'(ein[c]);
            end else begin
                i_sample_valid = 1'b0;
            end
            if (c >= 3) begin
                chk($sformatf("str_vld%0d", c - 3), int'(o_sample_valid), vin[c-3]);
                chk($sformatf("str_val%0d", c - 3), int'(o_sample), xout[c-3]);
            end
            tick();
        end

        // Reset while two samples are in flight.
        strobes = 0;
        i_sample_valid = 1'b1;
        i_sample       = 16'sd12000;
        i_env          = 16'hFFFF;
        tick();
        i_sample       = -16'sd9000;
        tick();
        i_sample_valid = 1'b0;
        i_reset_n      = 1'b0;
        tick();
        tick();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            strobes += int'(o_sample_valid);
        end
        chk("mid_rst_strobes", strobes, 0);
        chk("mid_rst_smp", int'(o_sample), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
